// File: rtl/wshb_stream_pattern.sv
// rtl/wshb_stream_pattern.sv - Wishbone read slave that serves a synthetic pixel pattern.
// Optional build macro PATTERN_SCROLL_EN scrolls patterns left by one pixel per frame.
module wshb_stream_pattern #(
  parameter int HDISP    = 800,
  parameter int VDISP    = 480,
  parameter int CHK_LOG2 = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [3:0]  sel,
  input  logic [2:0]  cti,
  input  logic [1:0]  bte,
  input  logic [31:0] dat_ms,
  output logic        ack,
  output logic [31:0] dat_sm,
  output logic        err,
  output logic        rty,
  input  logic [1:0]  mode,
  output logic        frame_start
);

  localparam logic [15:0] XMAX = 16'(HDISP - 1);
  localparam logic [15:0] YMAX = 16'(VDISP - 1);
  localparam logic [15:0] BMAX = 16'(HDISP / 8 - 1);

  // Pattern-space x plus its colour-bar position, tracked incrementally so no divider is needed.
  typedef struct packed {
    logic [15:0] pos;
    logic [15:0] bc;
    logic [2:0]  bi;
  } bar_pos_t;

  function automatic bar_pos_t step(input bar_pos_t p);
    bar_pos_t n;
    n = p;
    if (p.pos == XMAX) begin
      n = '0;
    end else begin
      n.pos = p.pos + 16'd1;
      if (p.bc == BMAX) begin
        n.bc = '0;
        n.bi = p.bi + 3'd1;
      end else begin
        n.bc = p.bc + 16'd1;
      end
    end
    return n;
  endfunction

  logic        ack_q, ack_d, err_q, err_d, fs_q, fs_d, single_q, single_d;
  logic [31:0] dat_sm_q, dat_sm_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic [1:0]  mode_q, mode_d, mode_eff;
  bar_pos_t    pos_q, pos_d, line_start_q, line_start_d;
  logic        req, wr, origin;
  logic [23:0] rgb;
  logic        unused_ok;

  assign req       = cyc & stb & ~we;
  assign wr        = cyc & stb & we;
  assign origin    = (x_q == 16'd0) && (y_q == 16'd0);
  assign mode_eff  = origin ? mode : mode_q;
  assign unused_ok = ^{adr, sel, bte, dat_ms};

  always_comb begin
    rgb = 24'h000000;
    case (mode_eff)
      2'd0: rgb = {{8{pos_q.bi[2]}}, {8{pos_q.bi[1]}}, {8{pos_q.bi[0]}}};
      2'd1: rgb = (pos_q.pos[CHK_LOG2] ^ y_q[CHK_LOG2]) ? 24'hFFFFFF : 24'h000000;
      2'd2: rgb = {3{pos_q.pos[7:0]}};
      default: rgb = 24'hFF0000;
    endcase
  end

  always_comb begin
    // A classic or end-of-burst ack forces a dead cycle before the next one.
    ack_d        = req & ~(ack_q & single_q);
    err_d        = wr & ~err_q;
    fs_d         = 1'b0;
    dat_sm_d     = dat_sm_q;
    single_d     = single_q;
    mode_d       = mode_q;
    x_d          = x_q;
    y_d          = y_q;
    fcnt_d       = fcnt_q;
    pos_d        = pos_q;
    line_start_d = line_start_q;
    if (ack_d) begin
      dat_sm_d = {8'h00, rgb};
      fs_d     = origin;
      single_d = (cti != 3'b010);
      mode_d   = mode_eff;
      if (x_q == XMAX) begin
        x_d = '0;
        if (y_q == YMAX) begin
          y_d    = '0;
          fcnt_d = fcnt_q + 8'd1;
`ifdef PATTERN_SCROLL_EN
          line_start_d = (fcnt_d == 8'd0) ? '0 : step(line_start_q);
`endif
        end else begin
          y_d = y_q + 16'd1;
        end
        pos_d = line_start_d;
      end else begin
        x_d   = x_q + 16'd1;
        pos_d = step(pos_q);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      fs_q         <= 1'b0;
      single_q     <= 1'b0;
      dat_sm_q     <= '0;
      mode_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      fcnt_q       <= '0;
      pos_q        <= '0;
      line_start_q <= '0;
    end else begin
      ack_q        <= ack_d;
      err_q        <= err_d;
      fs_q         <= fs_d;
      single_q     <= single_d;
      dat_sm_q     <= dat_sm_d;
      mode_q       <= mode_d;
      x_q          <= x_d;
      y_q          <= y_d;
      fcnt_q       <= fcnt_d;
      pos_q        <= pos_d;
      line_start_q <= line_start_d;
    end
  end

  assign ack         = ack_q;
  assign err         = err_q;
  assign rty         = 1'b0;
  assign dat_sm      = dat_sm_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_wshb_stream_pattern.sv
// tb/tb_wshb_stream_pattern.sv - Model-checked random and directed bench for wshb_stream_pattern.
module tb_wshb_stream_pattern;
  localparam int H = 16;
  localparam int V = 4;
  localparam int C = 2;
`ifdef PATTERN_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [2:0]  cti = 3'b000;
  logic [1:0]  mode = 2'd0;
  logic        ack, err, rty, frame_start;
  logic [31:0] dat_sm;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] acked[$];

  wshb_stream_pattern #(.HDISP(H), .VDISP(V), .CHK_LOG2(C)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .cyc(cyc), .stb(stb), .we(we),
    .adr(32'h0), .sel(4'hF), .cti(cti), .bte(2'b00), .dat_ms(32'h0),
    .ack(ack), .dat_sm(dat_sm), .err(err), .rty(rty),
    .mode(mode), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pixel(input int ex, input int y, input int m);
    int i;
    case (m)
      0: begin
        i = ex / (H / 8);
        return {8'h00, (i & 4) ? 8'hFF : 8'h00, (i & 2) ? 8'hFF : 8'h00, (i & 1) ? 8'hFF : 8'h00};
      end
      1: return (((ex >> C) ^ (y >> C)) & 1) ? 32'h00FFFFFF : 32'h0;
      2: return 32'(ex % 256) * 32'h00010101;
      default: return 32'h00FF0000;
    endcase
  endfunction

  // Reference model: screen position advances once per acked read word.
  initial begin
    int mx, my, mfc, mmode;
    bit p_ack, p_single, p_err;
    bit r, c, s, w, e_ack, e_err, e_fs, origin;
    logic [2:0] t;
    logic [1:0] md;
    logic [31:0] e_dat;
    mx = 0; my = 0; mfc = 0; mmode = 0; p_ack = 0; p_single = 0; p_err = 0;
    forever begin
      @(posedge clk);
      r = rst_n; c = cyc; s = stb; w = we; t = cti; md = mode;
      #1;
      e_fs = 0; e_dat = 32'h0;
      if (!r) begin
        e_ack = 0; e_err = 0;
        mx = 0; my = 0; mfc = 0; mmode = 0; p_ack = 0; p_single = 0; p_err = 0;
        chk("reset_dat", dat_sm, 32'h0);
      end else begin
        e_ack = c && s && !w && !(p_ack && p_single);
        e_err = c && s && w && !p_err;
        if (e_ack) begin
          origin = (mx == 0 && my == 0);
          if (origin) mmode = int'(md);
          e_dat = pixel((mx + (SCROLL ? mfc : 0)) % H, my, mmode);
          e_fs = origin;
          p_single = (t != 3'b010);
          mx++;
          if (mx == H) begin
            mx = 0; my++;
            if (my == V) begin my = 0; mfc = (mfc + 1) % 256; end
          end
          chk("dat_sm", dat_sm, e_dat);
        end
        p_ack = e_ack; p_err = e_err;
      end
      chk("ack", {31'h0, ack}, {31'h0, e_ack});
      chk("err", {31'h0, err}, {31'h0, e_err});
      chk("frame_start", {31'h0, frame_start}, {31'h0, e_fs});
      chk("rty", {31'h0, rty}, 32'h0);
      if (ack) acked.push_back(dat_sm);
    end
  end

  task automatic drive(input bit c, input bit s, input bit w, input logic [2:0] t);
    cyc = c; stb = s; we = w; cti = t;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input int idx, input logic [31:0] exp);
    if (idx < acked.size()) chk(name, acked[idx], exp);
    else chk({name, "_missing"}, 32'hDEAD_0000, exp);
  endtask

  initial begin
    int base;
    logic [31:0] bars[16];
    bars = '{32'h000000, 32'h000000, 32'h0000FF, 32'h0000FF, 32'h00FF00, 32'h00FF00,
             32'h00FFFF, 32'h00FFFF, 32'hFF0000, 32'hFF0000, 32'hFF00FF, 32'hFF00FF,
             32'hFFFF00, 32'hFFFF00, 32'hFFFFFF, 32'hFFFFFF};
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    base = acked.size();
    repeat (16) drive(1, 1, 0, 3'b010);
    drive(0, 0, 0, 3'b000); drive(0, 0, 0, 3'b000);
    for (int i = 0; i < 16; i++) lit("bars_burst", base + i, bars[i]);

    base = acked.size();
    repeat (16) drive(1, 1, 0, 3'b000);
    drive(0, 0, 0, 3'b000); drive(0, 0, 0, 3'b000);
    chk("classic_ack_count", 32'(acked.size() - base), 32'd8);

    repeat (5) drive(1, 1, 0, 3'b010);
    repeat (3) drive(1, 0, 0, 3'b010);
    repeat (4) drive(1, 1, 0, 3'b010);
    drive(1, 1, 0, 3'b111);
    drive(0, 0, 0, 3'b000);

    drive(1, 1, 1, 3'b000);
    drive(0, 0, 0, 3'b000);
    repeat (3) drive(1, 1, 0, 3'b010);
    drive(0, 1, 0, 3'b010);

    rst_n = 1'b0; drive(0, 0, 0, 3'b000); rst_n = 1'b1;
    mode = 2'd0;
    base = acked.size();
    repeat (20) drive(1, 1, 0, 3'b010);
    mode = 2'd3;
    repeat (45) drive(1, 1, 0, 3'b010);
    drive(0, 0, 0, 3'b000); drive(0, 0, 0, 3'b000);
    lit("bars_px19", base + 19, 32'h0000FF);
    lit("bars_px63", base + 63, 32'hFFFFFF);
    lit("red_next_frame", base + 64, 32'hFF0000);

    repeat (5) drive(1, 1, 0, 3'b010);
    rst_n = 1'b0; drive(1, 1, 0, 3'b010); rst_n = 1'b1;
    mode = 2'd2;
    base = acked.size();
    repeat (65) drive(1, 1, 0, 3'b010);
    drive(0, 0, 0, 3'b000); drive(0, 0, 0, 3'b000);
    lit("grad_origin", base, 32'h000000);
    lit("grad_frame2_origin", base + 64, SCROLL ? 32'h010101 : 32'h000000);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 599) != 0);
      case ($urandom_range(0, 3))
        0: cti = 3'b000;
        3: cti = 3'b111;
        default: cti = 3'b010;
      endcase
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, cti);
    end
    rst_n = 1'b1;
    drive(0, 0, 0, 3'b000); drive(0, 0, 0, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
